// File: rtl/alu_core_pkg.sv
// alu_core_pkg: shared constants and types for the sequential 8-bit ALU.
//   - operand/register widths, iteration count, op_code encodings
//   - one-hot state indices and the one-hot state enum
//   - ctrl_t: register/output control bundle from the control unit to the datapath
package alu_core_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned REG_W      = DATA_W + 1;
    localparam int unsigned ITER_COUNT = 8;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned NUM_STATES = 17;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int unsigned S_IDLE        = 0;
    localparam int unsigned S_LOAD_M      = 1;
    localparam int unsigned S_DISPATCH    = 2;
    localparam int unsigned S_ADD         = 3;
    localparam int unsigned S_SUB         = 4;
    localparam int unsigned S_MUL_TEST    = 5;
    localparam int unsigned S_MUL_ADD     = 6;
    localparam int unsigned S_MUL_SHIFT   = 7;
    localparam int unsigned S_DIV_SHIFT   = 8;
    localparam int unsigned S_DIV_SUB     = 9;
    localparam int unsigned S_DIV_RESTORE = 10;
    localparam int unsigned S_DIV_SETQ    = 11;
    localparam int unsigned S_COUNT       = 12;
    localparam int unsigned S_CNT_CHK     = 13;
    localparam int unsigned S_OUT_A       = 14;
    localparam int unsigned S_OUT_Q       = 15;
    localparam int unsigned S_DONE        = 16;

    typedef enum logic [NUM_STATES-1:0] {
        ST_IDLE        = NUM_STATES'(1) << S_IDLE,
        ST_LOAD_M      = NUM_STATES'(1) << S_LOAD_M,
        ST_DISPATCH    = NUM_STATES'(1) << S_DISPATCH,
        ST_ADD         = NUM_STATES'(1) << S_ADD,
        ST_SUB         = NUM_STATES'(1) << S_SUB,
        ST_MUL_TEST    = NUM_STATES'(1) << S_MUL_TEST,
        ST_MUL_ADD     = NUM_STATES'(1) << S_MUL_ADD,
        ST_MUL_SHIFT   = NUM_STATES'(1) << S_MUL_SHIFT,
        ST_DIV_SHIFT   = NUM_STATES'(1) << S_DIV_SHIFT,
        ST_DIV_SUB     = NUM_STATES'(1) << S_DIV_SUB,
        ST_DIV_RESTORE = NUM_STATES'(1) << S_DIV_RESTORE,
        ST_DIV_SETQ    = NUM_STATES'(1) << S_DIV_SETQ,
        ST_COUNT       = NUM_STATES'(1) << S_COUNT,
        ST_CNT_CHK     = NUM_STATES'(1) << S_CNT_CHK,
        ST_OUT_A       = NUM_STATES'(1) << S_OUT_A,
        ST_OUT_Q       = NUM_STATES'(1) << S_OUT_Q,
        ST_DONE        = NUM_STATES'(1) << S_DONE
    } state_e;

    typedef struct packed {
        logic load_q;
        logic load_m;
        logic do_add;
        logic do_sub;
        logic mul_add;
        logic mul_shift;
        logic div_shift;
        logic div_sub;
        logic div_restore;
        logic div_setq;
        logic out_a;
        logic out_q;
        logic done;
    } ctrl_t;

endpackage

// File: rtl/alu_core_control_unit.sv
// alu_control_unit: one-hot sequencer and iteration counter for alu_core.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   begin_i, op_code_i    start strobe and operation, sampled in IDLE/DONE
//   q_lsb_i               Q[0], multiplier bit under test
//   sub_neg_i             sign of A-M, selects restore vs set-quotient
//   ctrl_c                decoded register/output controls for the current state
//   act_state_debug_o     current one-hot state (0 unless ALU_DEBUG_EN)
//   next_state_debug_o    next one-hot state   (0 unless ALU_DEBUG_EN)
module alu_control_unit
    import alu_core_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  begin_i,
    input  logic [1:0]            op_code_i,
    input  logic                  q_lsb_i,
    input  logic                  sub_neg_i,
    output ctrl_t                 ctrl_c,
    output logic [NUM_STATES-1:0] act_state_debug_o,
    output logic [NUM_STATES-1:0] next_state_debug_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;

    // State, counter and latched op register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ctrl_c  = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                ctrl_c.done = (state_q == ST_DONE);
                if (begin_i) begin
                    ctrl_c.load_q = 1'b1;
                    cnt_d         = '0;
                    op_d          = op_code_i;
                    state_d       = ST_LOAD_M;
                end
            end
            ST_LOAD_M: begin
                ctrl_c.load_m = 1'b1;
                state_d       = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                case (op_q)
                    OP_ADD:  state_d = ST_ADD;
                    OP_SUB:  state_d = ST_SUB;
                    OP_MUL:  state_d = ST_MUL_TEST;
                    default: state_d = ST_DIV_SHIFT;
                endcase
            end
            ST_ADD: begin
                ctrl_c.do_add = 1'b1;
                state_d       = ST_OUT_Q;
            end
            ST_SUB: begin
                ctrl_c.do_sub = 1'b1;
                state_d       = ST_OUT_Q;
            end
            ST_MUL_TEST: begin
                state_d = q_lsb_i ? ST_MUL_ADD : ST_MUL_SHIFT;
            end
            ST_MUL_ADD: begin
                ctrl_c.mul_add = 1'b1;
                state_d        = ST_MUL_SHIFT;
            end
            ST_MUL_SHIFT: begin
                ctrl_c.mul_shift = 1'b1;
                state_d          = ST_COUNT;
            end
            ST_DIV_SHIFT: begin
                ctrl_c.div_shift = 1'b1;
                state_d          = ST_DIV_SUB;
            end
            // Branch on the sign of the difference being written this cycle
            ST_DIV_SUB: begin
                ctrl_c.div_sub = 1'b1;
                state_d        = sub_neg_i ? ST_DIV_RESTORE : ST_DIV_SETQ;
            end
            ST_DIV_RESTORE: begin
                ctrl_c.div_restore = 1'b1;
                state_d            = ST_COUNT;
            end
            ST_DIV_SETQ: begin
                ctrl_c.div_setq = 1'b1;
                state_d         = ST_COUNT;
            end
            ST_COUNT: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ST_CNT_CHK;
            end
            ST_CNT_CHK: begin
                if (cnt_q == CNT_W'(ITER_COUNT)) begin
                    state_d = ST_OUT_A;
                end else if (op_q == OP_MUL) begin
                    state_d = ST_MUL_TEST;
                end else begin
                    state_d = ST_DIV_SHIFT;
                end
            end
            ST_OUT_A: begin
                ctrl_c.out_a = 1'b1;
                state_d      = ST_OUT_Q;
            end
            ST_OUT_Q: begin
                ctrl_c.out_q = 1'b1;
                state_d      = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef ALU_DEBUG_EN
    assign act_state_debug_o  = state_q;
    assign next_state_debug_o = state_d;
`else
    assign act_state_debug_o  = '0;
    assign next_state_debug_o = '0;
`endif

endmodule

// File: rtl/alu_core.sv
// alu_core: sequential 8-bit add/sub/mul/div over a shared operand byte bus.
// Optional build macro ALU_DEBUG_EN drives the five debug ports; otherwise they read 0.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   BEGIN, op_code, inbus   start strobe, op (00 add 01 sub 10 mul 11 div), operand bus
//   outbus                  result byte (A in OUT_A, Q in OUT_Q/DONE, else 0)
//   END                     high while in DONE
//   act_state_debug, next_state_debug   one-hot current/next state
//   A_reg_debug, Q_reg_debug, M_reg_debug  9-bit register contents
module alu_core
    import alu_core_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  BEGIN,
    input  logic [1:0]            op_code,
    input  logic [DATA_W-1:0]     inbus,
    output logic [DATA_W-1:0]     outbus,
    output logic                  END,
    output logic [NUM_STATES-1:0] act_state_debug,
    output logic [NUM_STATES-1:0] next_state_debug,
    output logic [REG_W-1:0]      A_reg_debug,
    output logic [REG_W-1:0]      Q_reg_debug,
    output logic [REG_W-1:0]      M_reg_debug
);

    ctrl_t            ctrl;
    logic [REG_W-1:0] a_q, a_d;
    logic [REG_W-1:0] q_q, q_d;
    logic [REG_W-1:0] m_q, m_d;
    logic [REG_W-1:0] sum_c, diff_c;

    assign sum_c  = REG_W'(a_q + m_q);
    assign diff_c = REG_W'(a_q - m_q);

    alu_control_unit u_ctrl (
        .clk                (clk),
        .reset              (reset),
        .begin_i            (BEGIN),
        .op_code_i          (op_code),
        .q_lsb_i            (q_q[0]),
        .sub_neg_i          (diff_c[REG_W-1]),
        .ctrl_c             (ctrl),
        .act_state_debug_o  (act_state_debug),
        .next_state_debug_o (next_state_debug)
    );

    // A/Q/M registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            q_q <= '0;
            m_q <= '0;
        end else begin
            a_q <= a_d;
            q_q <= q_d;
            m_q <= m_d;
        end
    end

    // Datapath next-state; Q[8] is never set, so 9-bit add/sub truncate cleanly
    always_comb begin
        a_d = a_q;
        q_d = q_q;
        m_d = m_q;
        if (ctrl.load_q) begin
            q_d = {1'b0, inbus};
            a_d = '0;
        end
        if (ctrl.load_m) begin
            m_d = {1'b0, inbus};
        end
        if (ctrl.do_add) begin
            q_d = {1'b0, DATA_W'(q_q + m_q)};
        end
        if (ctrl.do_sub) begin
            q_d = {1'b0, DATA_W'(q_q - m_q)};
        end
        if (ctrl.mul_add) begin
            a_d = sum_c;
        end
        if (ctrl.mul_shift) begin
            {a_d, q_d[DATA_W-1:0]} = {a_q, q_q[DATA_W-1:0]} >> 1;
        end
        if (ctrl.div_shift) begin
            {a_d, q_d[DATA_W-1:0]} = {a_q, q_q[DATA_W-1:0]} << 1;
        end
        if (ctrl.div_sub) begin
            a_d = diff_c;
        end
        if (ctrl.div_restore) begin
            a_d    = sum_c;
            q_d[0] = 1'b0;
        end
        if (ctrl.div_setq) begin
            q_d[0] = 1'b1;
        end
    end

    // Result bus decoded from the registered state
    always_comb begin
        outbus = '0;
        if (ctrl.out_a) begin
            outbus = a_q[DATA_W-1:0];
        end else if (ctrl.out_q || ctrl.done) begin
            outbus = q_q[DATA_W-1:0];
        end
    end

    assign END = ctrl.done;

`ifdef ALU_DEBUG_EN
    assign A_reg_debug = a_q;
    assign Q_reg_debug = q_q;
    assign M_reg_debug = m_q;
`else
    assign A_reg_debug = '0;
    assign Q_reg_debug = '0;
    assign M_reg_debug = '0;
`endif

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed + random transactions on alu_core, checked against an
// arithmetic reference (results and END latency computed from operand values).
module tb_alu_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        BEGIN;
    logic [1:0]  op_code;
    logic [7:0]  inbus;
    logic [7:0]  outbus;
    logic        END;
    logic [16:0] act_state_debug;
    logic [16:0] next_state_debug;
    logic [8:0]  A_reg_debug;
    logic [8:0]  Q_reg_debug;
    logic [8:0]  M_reg_debug;

    int total = 0;
    int bad   = 0;

`ifdef ALU_DEBUG_EN
    localparam logic [16:0] IDLE_DBG = 17'h00001;
`else
    localparam logic [16:0] IDLE_DBG = 17'h00000;
`endif

    alu_core dut (
        .clk              (clk),
        .reset            (reset),
        .BEGIN            (BEGIN),
        .op_code          (op_code),
        .inbus            (inbus),
        .outbus           (outbus),
        .END              (END),
        .act_state_debug  (act_state_debug),
        .next_state_debug (next_state_debug),
        .A_reg_debug      (A_reg_debug),
        .Q_reg_debug      (Q_reg_debug),
        .M_reg_debug      (M_reg_debug)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Idle/reset view of every output
    task automatic chk_idle(input string tag);
        chk({tag, "_outbus"}, 32'(outbus), 32'h0);
        chk({tag, "_end"}, 32'(END), 32'h0);
        chk({tag, "_state"}, 32'(act_state_debug), 32'(IDLE_DBG));
        chk({tag, "_regs"}, {5'd0, A_reg_debug, Q_reg_debug, M_reg_debug}, 32'h0);
    endtask

    // One transaction started from IDLE or DONE; a = first operand, b = second
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
        logic [15:0] prod;
        int          lat;
        bit          quiet;
        bit          has_a;
        exp_hi = 8'h00;
        has_a  = (op[1] == 1'b1);
        case (op)
            2'b00: begin exp_lo = a + b; lat = 4; end
            2'b01: begin exp_lo = a - b; lat = 4; end
            2'b10: begin
                prod   = 16'(a) * 16'(b);
                exp_hi = prod[15:8];
                exp_lo = prod[7:0];
                lat    = 36 + $countones(a);
            end
            default: begin
                if (b == 8'd0) begin
                    exp_lo = 8'hFF;
                    exp_hi = a;
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
                lat = 44;
            end
        endcase
        BEGIN   = 1'b1;
        op_code = op;
        inbus   = a;
        quiet   = 1'b1;
        for (int n = 0; n <= lat; n++) begin
            tick();
            if (n == 0) begin
                BEGIN   = 1'b0;
                op_code = 2'($urandom_range(0, 3));
                inbus   = b;
            end else if (n == 1) begin
                inbus = 8'($urandom);
            end
            if (n == lat) begin
                chk($sformatf("end_op%0d", op), 32'(END), 32'h1);
                chk($sformatf("done_bus_op%0d", op), 32'(outbus), 32'(exp_lo));
            end else if (n == lat - 1) begin
                chk($sformatf("out_q_op%0d", op), {23'd0, END, outbus}, 32'(exp_lo));
            end else if (has_a && n == lat - 2) begin
                chk($sformatf("out_a_op%0d", op), {23'd0, END, outbus}, 32'(exp_hi));
            end else if (outbus !== 8'h00 || END !== 1'b0) begin
                quiet = 1'b0;
            end
        end
        chk($sformatf("quiet_op%0d", op), 32'(quiet), 32'h1);
    endtask

    initial begin
        reset   = 1'b1;
        BEGIN   = 1'b0;
        op_code = 2'b00;
        inbus   = 8'h00;
        tick();
        tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();
        chk_idle("idle_hold");
        chk("idle_next", 32'(next_state_debug), 32'(IDLE_DBG));

        run_op(2'b00, 8'd56, 8'd89);
        run_op(2'b01, 8'd56, 8'd89);
        run_op(2'b10, 8'd56, 8'd89);
        run_op(2'b11, 8'd123, 8'd89);
        run_op(2'b11, 8'd200, 8'd0);
        run_op(2'b10, 8'hFF, 8'hFF);
        run_op(2'b10, 8'h00, 8'hAB);
        run_op(2'b11, 8'h07, 8'hFF);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = (i % 8 == 7) ? 8'h00 : 8'($urandom);
            run_op(2'($urandom_range(0, 3)), ra, rb);
        end

        // Reset in the middle of a multiply, with BEGIN held high during reset
        BEGIN   = 1'b1;
        op_code = 2'b10;
        inbus   = 8'd56;
        tick();
        BEGIN = 1'b0;
        inbus = 8'd89;
        for (int n = 0; n < 12; n++) tick();
        reset = 1'b1;
        BEGIN = 1'b1;
        inbus = 8'd7;
        tick();
        chk_idle("mid_reset");
        tick();
        chk_idle("reset_begin_ignored");
        reset = 1'b0;
        BEGIN = 1'b0;
        tick();
        chk_idle("post_reset");
        run_op(2'b00, 8'd1, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
